// File: rtl/wbs_leaf_loader_if.sv
// Wishbone classic slave-side bundle for wbs_leaf_loader.
// Signal names match the original flat port list so the wiring reads the same.
interface wbs_leaf_loader_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wbs_leaf_loader.sv
// wbs_leaf_loader: Wishbone slave giving word access to the leaf SRAM banks.
// Two 32-bit writes are packed into a 64-bit shadow; the high-half write
// commits the shadow to the decoded bank/word. Reads fetch a 64-bit leaf word
// and return the addressed half.
// Optional feature macro: WBS_LEAF_READBACK_EN (SRAM readback path; when
// undefined reads acknowledge immediately with zero data).
module wbs_leaf_loader #(
    parameter int          LEAF_SIZE  = 8,
    parameter int          NUM_LEAVES = 64,
    parameter int          LEAF_ADDRW = $clog2(NUM_LEAVES),
    parameter logic [31:0] ADDR_BASE  = 32'h3000_1000
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    wbs_leaf_loader_if.slave              wbs,
    input  logic                          wbs_debug,
    output logic [LEAF_SIZE-1:0]          wbs_leaf_mem_csb0,
    output logic [LEAF_SIZE-1:0]          wbs_leaf_mem_web0,
    output logic [LEAF_ADDRW-1:0]         wbs_leaf_mem_addr0,
    output logic [63:0]                   wbs_leaf_mem_wleaf0,
    input  logic [LEAF_SIZE-1:0][63:0]    wbs_leaf_mem_rleaf0
);

    localparam int BANKW = $clog2(LEAF_SIZE);
    localparam int WINW  = $clog2(NUM_LEAVES * LEAF_SIZE * 8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_WR
`ifdef WBS_LEAF_READBACK_EN
        ,
        S_RD,
        S_RCAP
`endif
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [63:0]           r_shadow;
    logic [BANKW-1:0]      r_bank;
    logic [LEAF_ADDRW-1:0] r_addr;
    logic                  r_half;
    logic [31:0]           r_dat;

    logic                  w_ack;
    logic                  w_in_win;
    logic                  w_hit;
    logic [WINW-1:0]       w_off;
    logic                  w_half;
    logic [BANKW-1:0]      w_bank;
    logic [LEAF_ADDRW-1:0] w_waddr;
    logic                  w_unused;

    // Window decode: the window is size-aligned, so the offset is just the low bits.
    assign w_off    = wbs.wbs_adr_i[WINW-1:0];
    assign w_in_win = (wbs.wbs_adr_i[31:WINW] == ADDR_BASE[31:WINW]);
    assign w_hit    = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~w_ack & w_in_win;
    assign w_half   = w_off[2];
    assign w_bank   = w_off[3 +: BANKW];
    assign w_waddr  = w_off[3 + BANKW +: LEAF_ADDRW];

`ifdef WBS_LEAF_READBACK_EN
    assign w_unused = ^wbs.wbs_adr_i[1:0];
`else
    assign w_unused = ^{wbs.wbs_adr_i[1:0], wbs_leaf_mem_rleaf0, r_half};
`endif

    // State register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state decode; wbs_debug only matters at acceptance in IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_hit) begin
                    if (!wbs_debug)         w_next = S_ACK;
                    else if (wbs.wbs_we_i)  w_next = w_half ? S_WR : S_ACK;
`ifdef WBS_LEAF_READBACK_EN
                    else                    w_next = S_RD;
`else
                    else                    w_next = S_ACK;
`endif
                end
            end
            S_WR:   w_next = S_ACK;
`ifdef WBS_LEAF_READBACK_EN
            S_RD:   w_next = S_RCAP;
            S_RCAP: w_next = S_ACK;
`endif
            S_ACK:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Shadow merge, address latch and read-data capture.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_shadow <= '0;
            r_bank   <= '0;
            r_addr   <= '0;
            r_half   <= 1'b0;
            r_dat    <= '0;
        end else if (r_state == S_IDLE && w_hit) begin
            if (wbs_debug) begin
                r_bank <= w_bank;
                r_addr <= w_waddr;
                r_half <= w_half;
                if (wbs.wbs_we_i) begin
                    for (int unsigned i = 0; i < 4; i++) begin
                        if (wbs.wbs_sel_i[i]) begin
                            if (w_half) r_shadow[32 + 8*i +: 8] <= wbs.wbs_dat_i[8*i +: 8];
                            else        r_shadow[8*i +: 8]      <= wbs.wbs_dat_i[8*i +: 8];
                        end
                    end
                end
`ifndef WBS_LEAF_READBACK_EN
                else begin
                    r_dat <= '0;
                end
`endif
            end else if (!wbs.wbs_we_i) begin
                r_dat <= '0;
            end
        end
`ifdef WBS_LEAF_READBACK_EN
        else if (r_state == S_RCAP) begin
            r_dat <= r_half ? wbs_leaf_mem_rleaf0[r_bank][63:32]
                            : wbs_leaf_mem_rleaf0[r_bank][31:0];
        end
`endif
    end

    // Output decode: one-hot active-low strobe only in WR/RD, ack only in ACK.
    always_comb begin
        w_ack             = (r_state == S_ACK);
        wbs_leaf_mem_csb0 = '1;
        wbs_leaf_mem_web0 = '1;
        case (r_state)
            S_WR: begin
                wbs_leaf_mem_csb0[r_bank] = 1'b0;
                wbs_leaf_mem_web0[r_bank] = 1'b0;
            end
`ifdef WBS_LEAF_READBACK_EN
            S_RD: wbs_leaf_mem_csb0[r_bank] = 1'b0;
`endif
            default: ;
        endcase
    end

    assign wbs.wbs_ack_o           = w_ack;
    assign wbs.wbs_dat_o           = r_dat;
    assign wbs_leaf_mem_addr0      = r_addr;
    assign wbs_leaf_mem_wleaf0     = r_shadow;

endmodule

// File: tb/tb_wbs_leaf_loader.sv
// Directed, table-driven bench for wbs_leaf_loader with a simple SRAM model.
module tb_wbs_leaf_loader;

    localparam logic [31:0] BASE = 32'h3000_1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dbg = 1'b0;
    logic [7:0]       csb, web;
    logic [5:0]       maddr;
    logic [63:0]      wleaf;
    logic [7:0][63:0] rleaf;
    logic [63:0]      mem [8][64];

    int total = 0;
    int bad   = 0;

    wbs_leaf_loader_if bus();

    wbs_leaf_loader #(
        .LEAF_SIZE (8),
        .NUM_LEAVES(64),
        .LEAF_ADDRW(6),
        .ADDR_BASE (BASE)
    ) dut (
        .wb_clk_i           (clk),
        .wb_rst_i           (rst),
        .wbs                (bus),
        .wbs_debug          (dbg),
        .wbs_leaf_mem_csb0  (csb),
        .wbs_leaf_mem_web0  (web),
        .wbs_leaf_mem_addr0 (maddr),
        .wbs_leaf_mem_wleaf0(wleaf),
        .wbs_leaf_mem_rleaf0(rleaf)
    );

    always #5 clk = ~clk;

    // SRAM model: bank 3 word 0 preloaded; read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 8; b++) begin
                for (int a = 0; a < 64; a++) mem[b][a] <= 64'h0;
                rleaf[b] <= 64'h0;
            end
            mem[3][0] <= 64'hDEAD_BEEF_CAFE_F00D;
        end else begin
            for (int b = 0; b < 8; b++) begin
                if (!csb[b]) begin
                    if (!web[b]) mem[b][maddr] <= wleaf;
                    else         rleaf[b]      <= mem[b][maddr];
                end
            end
        end
    end

    typedef struct {
        logic        we;
        logic        dbg;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          lat;
        int          nstb;
        logic [7:0]  csb;
        logic [7:0]  web;
        logic [5:0]  addr;
        logic [63:0] wleaf;
        logic [31:0] rdat;
    } vec_t;

    function automatic vec_t mk(logic we, logic d, logic [31:0] adr, logic [3:0] sel,
                                logic [31:0] dat, int lat, int nstb, logic [7:0] c,
                                logic [7:0] w, logic [5:0] a, logic [63:0] wl, logic [31:0] rd);
        vec_t v;
        v.we = we; v.dbg = d; v.adr = adr; v.sel = sel; v.dat = dat;
        v.lat = lat; v.nstb = nstb; v.csb = c; v.web = w; v.addr = a;
        v.wleaf = wl; v.rdat = rd;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic idle_bus();
        bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = 4'h0; bus.wbs_dat_i = 32'h0; bus.wbs_adr_i = 32'h0;
    endtask

    task automatic drive(input vec_t v);
        bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = v.we;
        bus.wbs_sel_i = v.sel; bus.wbs_dat_i = v.dat; bus.wbs_adr_i = v.adr;
        dbg = v.dbg;
    endtask

    // One bus transfer over a bounded 6-cycle window; records ack timing and strobes.
    task automatic run_vec(input vec_t v, input string tag);
        int ack_at, nack, nstb;
        logic [7:0]  c_s, w_s;
        logic [5:0]  a_s;
        logic [63:0] wl_s;
        ack_at = 0; nack = 0; nstb = 0;
        c_s = 8'hFF; w_s = 8'hFF; a_s = 6'h0; wl_s = 64'h0;
        @(negedge clk);
        drive(v);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (bus.wbs_ack_o) begin
                nack++;
                if (ack_at == 0) ack_at = k;
                idle_bus();
            end
            if (csb !== 8'hFF) begin
                nstb++;
                c_s = csb; w_s = web; a_s = maddr; wl_s = wleaf;
            end
        end
        idle_bus();
        check({tag, ".ack_lat"}, 64'(ack_at), 64'(v.lat));
        check({tag, ".ack_cnt"}, 64'(nack), (v.lat > 0) ? 64'd1 : 64'd0);
        check({tag, ".strobes"}, 64'(nstb), 64'(v.nstb));
        if (v.nstb > 0) begin
            check({tag, ".csb"},  64'(c_s), 64'(v.csb));
            check({tag, ".web"},  64'(w_s), 64'(v.web));
            check({tag, ".addr"}, 64'(a_s), 64'(v.addr));
            if (v.we) check({tag, ".wleaf"}, wl_s, v.wleaf);
        end
        if (!v.we && v.lat > 0) check({tag, ".dat_o"}, 64'(bus.wbs_dat_o), 64'(v.rdat));
    endtask

    vec_t vt[16];
    vec_t vr;

    initial begin
        // writes: shadow evolves across entries; expected wleaf hand-computed
        vt[0]  = mk(1, 1, BASE + 32'h000, 4'hF, 32'h89AB_CDEF, 1, 0, 8'hFF, 8'hFF, 0, 64'h0, 0);
        vt[1]  = mk(1, 1, BASE + 32'h004, 4'hF, 32'h0123_4567, 2, 1, 8'hFE, 8'hFE, 0, 64'h0123_4567_89AB_CDEF, 0);
        vt[2]  = mk(1, 1, BASE + 32'h0BC, 4'hF, 32'hAAAA_5555, 2, 1, 8'h7F, 8'h7F, 2, 64'hAAAA_5555_89AB_CDEF, 0);
        vt[3]  = mk(1, 1, BASE + 32'h048, 4'hF, 32'h0000_0000, 1, 0, 8'hFF, 8'hFF, 0, 64'h0, 0);
        vt[4]  = mk(1, 1, BASE + 32'h048, 4'h3, 32'hFFFF_1234, 1, 0, 8'hFF, 8'hFF, 0, 64'h0, 0);
        vt[5]  = mk(1, 1, BASE + 32'h04C, 4'hF, 32'h0BAD_0BAD, 2, 1, 8'hFD, 8'hFD, 1, 64'h0BAD_0BAD_0000_1234, 0);
        vt[6]  = mk(1, 1, BASE + 32'h04C, 4'hC, 32'h7777_8888, 2, 1, 8'hFD, 8'hFD, 1, 64'h7777_0BAD_0000_1234, 0);
        vt[7]  = mk(1, 0, BASE + 32'h048, 4'hF, 32'hFFFF_FFFF, 1, 0, 8'hFF, 8'hFF, 0, 64'h0, 0);
        vt[8]  = mk(1, 0, BASE + 32'h04C, 4'hF, 32'h1212_1212, 1, 0, 8'hFF, 8'hFF, 0, 64'h0, 0);
        vt[9]  = mk(1, 1, BASE + 32'h04C, 4'h0, 32'hFFFF_FFFF, 2, 1, 8'hFD, 8'hFD, 1, 64'h7777_0BAD_0000_1234, 0);
        // outside the window: no ack
        vt[10] = mk(1, 1, BASE + 32'h1000, 4'hF, 32'h5A5A_5A5A, 0, 0, 8'hFF, 8'hFF, 0, 64'h0, 0);
        vt[11] = mk(0, 1, BASE - 32'h4,   4'hF, 32'h0,         0, 0, 8'hFF, 8'hFF, 0, 64'h0, 0);
`ifdef WBS_LEAF_READBACK_EN
        vt[12] = mk(0, 1, BASE + 32'h01C, 4'hF, 32'h0, 3, 1, 8'hF7, 8'hFF, 0, 64'h0, 32'hDEAD_BEEF);
        vt[13] = mk(0, 1, BASE + 32'h018, 4'hF, 32'h0, 3, 1, 8'hF7, 8'hFF, 0, 64'h0, 32'hCAFE_F00D);
        vt[14] = mk(0, 1, BASE + 32'h0BC, 4'hF, 32'h0, 3, 1, 8'h7F, 8'hFF, 2, 64'h0, 32'hAAAA_5555);
`else
        vt[12] = mk(0, 1, BASE + 32'h01C, 4'hF, 32'h0, 1, 0, 8'hFF, 8'hFF, 0, 64'h0, 32'h0);
        vt[13] = mk(0, 1, BASE + 32'h018, 4'hF, 32'h0, 1, 0, 8'hFF, 8'hFF, 0, 64'h0, 32'h0);
        vt[14] = mk(0, 1, BASE + 32'h0BC, 4'hF, 32'h0, 1, 0, 8'hFF, 8'hFF, 0, 64'h0, 32'h0);
`endif
        vt[15] = mk(0, 0, BASE + 32'h01C, 4'hF, 32'h0, 1, 0, 8'hFF, 8'hFF, 0, 64'h0, 32'h0);

        idle_bus();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst.csb",   64'(csb), 64'hFF);
        check("rst.web",   64'(web), 64'hFF);
        check("rst.ack",   64'(bus.wbs_ack_o), 64'h0);
        check("rst.dat_o", 64'(bus.wbs_dat_o), 64'h0);
        check("rst.addr",  64'(maddr), 64'h0);
        check("rst.wleaf", wleaf, 64'h0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Request held through ack: not re-accepted in the ack cycle, re-accepted after.
        @(negedge clk);
        vr = mk(1, 1, BASE + 32'h000, 4'hF, 32'h1111_2222, 0, 0, 8'hFF, 8'hFF, 0, 64'h0, 0);
        drive(vr);
        @(negedge clk); check("b2b.ack1", 64'(bus.wbs_ack_o), 64'h1);
        @(negedge clk); check("b2b.ack2", 64'(bus.wbs_ack_o), 64'h0);
        @(negedge clk); check("b2b.ack3", 64'(bus.wbs_ack_o), 64'h1);
        idle_bus();
        @(negedge clk); check("b2b.ack4", 64'(bus.wbs_ack_o), 64'h0);

        // Reset sampled with a high-half write: write dropped, no ack.
        @(negedge clk);
        vr = mk(1, 1, BASE + 32'h004, 4'hF, 32'h3333_4444, 0, 0, 8'hFF, 8'hFF, 0, 64'h0, 0);
        drive(vr);
        rst = 1'b1;
        @(negedge clk);
        check("rstwr.csb", 64'(csb), 64'hFF);
        check("rstwr.ack", 64'(bus.wbs_ack_o), 64'h0);
        idle_bus();
        rst = 1'b0;
        @(negedge clk);
        check("rstwr.csb2", 64'(csb), 64'hFF);
        check("rstwr.ack2", 64'(bus.wbs_ack_o), 64'h0);

`ifdef WBS_LEAF_READBACK_EN
        // Reset asserted during the RD strobe cycle.
        vr = mk(0, 1, BASE + 32'h01C, 4'hF, 32'h0, 0, 0, 8'hFF, 8'hFF, 0, 64'h0, 0);
        drive(vr);
        @(negedge clk);
        check("rstrd.csb_rd", 64'(csb), 64'hF7);
        idle_bus();
        rst = 1'b1;
        @(negedge clk);
        check("rstrd.csb", 64'(csb), 64'hFF);
        check("rstrd.ack", 64'(bus.wbs_ack_o), 64'h0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("rstrd.noack%0d", k), 64'(bus.wbs_ack_o), 64'h0);
        end
        vr = mk(0, 1, BASE + 32'h01C, 4'hF, 32'h0, 3, 1, 8'hF7, 8'hFF, 0, 64'h0, 32'hDEAD_BEEF);
`else
        vr = mk(0, 1, BASE + 32'h01C, 4'hF, 32'h0, 1, 0, 8'hFF, 8'hFF, 0, 64'h0, 32'h0);
`endif
        run_vec(vr, "post_rst_read");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
